store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//  Holds in-flight stores in program order between dispatch and memory. Entries are allocated
//  at rename, filled with address/data by the LSU over the CDB side-band, marked committed by
//  the ROB pop (rob_sb_valid_o), then drained one per handshake to the data memory. On ROB
//  mispredict, uncommitted entries are discarded; committed entries still drain.
// PARAMETERS
//  SB_ENTRY     8            number of entries, power of 2, >=2
//  WORD_SIZE_P  16           address and data width
// PORTS
//  clk_i               in   1                  clock
//  reset_i             in   1                  async active-high reset
//  rename_sb_valid_i   in   1                  allocate a store entry this cycle
//  sb_rename_ready_o   out  1                  entry available (count<SB_ENTRY, no mispredict)
//  sb_rename_idx_o     out  $clog2(SB_ENTRY)   index of the entry being allocated (= tail)
//  exe_sb_valid_i      in   1                  LSU writes address/data to an entry
//  exe_sb_idx_i        in   $clog2(SB_ENTRY)   target entry
//  exe_sb_addr_i       in   WORD_SIZE_P        store address
//  exe_sb_data_i       in   WORD_SIZE_P        store data
//  rob_sb_valid_i      in   1                  ROB commits the oldest uncommitted store
//  rob_mispredict_i    in   1                  flush all uncommitted entries
//  ld_addr_i           in   WORD_SIZE_P        load forwarding lookup address
//  sb_ld_hit_o         out  1                  youngest matching filled entry found
//  sb_ld_data_o        out  WORD_SIZE_P        forwarded data (0 when no hit)
//  sb_mem_valid_o      out  1                  head entry committed, write request
//  sb_mem_addr_o       out  WORD_SIZE_P        write address
//  sb_mem_data_o       out  WORD_SIZE_P        write data
//  mem_sb_ready_i      in   1                  memory accepts the write
// BEHAVIOUR
//  - State: entry array {valid, filled, committed, addr, data}; pointers head (drain),
//    cmt (next commit), tail (alloc); count in [0..SB_ENTRY] (width $clog2(SB_ENTRY)+1).
//  - Reset (async): all entries cleared, pointers 0, count 0. Outputs: ready=1, idx=0,
//    mem_valid=0, mem_addr/data=0, ld_hit=0, ld_data=0.
//  - Alloc: on valid&ready, entry[tail] <= {valid=1, others 0}; tail++ (wraps mod SB_ENTRY).
//    ready is from registered count only; full blocks alloc even if a drain fires that cycle.
//  - Fill: exe write to a valid, uncommitted entry sets addr/data, filled=1. Writes to
//    invalid entries are dropped. Same-cycle alloc and fill of one index: fill is dropped.
//  - Commit: rob_sb_valid_i sets entry[cmt].committed=1, cmt++. Entry is filled by
//    construction (ROB pops only after writeback). Pop with no uncommitted entry: ignored.
//  - Drain: sb_mem_valid_o = entry[head].valid & committed; addr/data held stable until
//    mem_sb_ready_i. On handshake: entry cleared, head++, count--. Commit-to-valid: 1 cycle.
//  - Mispredict: all entries from cmt to tail-1 cleared, tail <= cmt; count <= committed
//    count (minus 1 if a drain handshake fires the same cycle). Pop, alloc and fill are
//    ignored that cycle; drain proceeds normally; ready=0.
//  - Simultaneous alloc + drain: count unchanged. Commit does not change count.
//  - Forwarding (combinational): scan from tail-1 back to head; first valid & filled entry
//    with addr==ld_addr_i gives hit=1, data=entry data. Unfilled entries are skipped.
//  - Pointer wrap: all pointers wrap mod SB_ENTRY; full/empty distinguished by count only.
// TESTING
//  1. Reset mid-drain (mem_valid=1, ready=0): next cycle mem_valid=0, ready=1, count=0.
//  2. Alloc 3, fill idx0 {0x0100,0xBEEF}, pop -> next cycle mem_valid=1, addr 0x0100, data
//     0xBEEF; hold ready=0 3 cycles, outputs stable; ready=1 -> head=1, count=2.
//  3. Fill entries 0,2 with addr 0x0040 data 0x1111/0x2222 -> ld_addr 0x0040 gives hit,
//     0x2222; ld_addr 0x0041 gives hit=0, data 0.
//  4. Alloc 5, commit 2, mispredict -> tail=cmt=2, count=2, ready=0 that cycle; both
//     committed entries then drain; entries 2-4 never reach memory.
//  5. Fill SB_ENTRY entries: ready=0; drain one with alloc asserted -> no alloc that cycle,
//     ready=1 next; alloc at tail 0 after wrap returns idx 0.
//  6. Pop with no uncommitted entry and exe write to invalid idx -> no state change.

Source files
------------

// File: rtl/store_buffer.sv
// In-order store buffer: allocate at rename, fill from the LSU, commit from the ROB,
// drain committed stores to memory, with youngest-match load forwarding.
module store_buffer #(
  parameter int SB_ENTRY    = 8,
  parameter int WORD_SIZE_P = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        rename_sb_valid_i,
  output logic                        sb_rename_ready_o,
  output logic [$clog2(SB_ENTRY)-1:0] sb_rename_idx_o,
  input  logic                        exe_sb_valid_i,
  input  logic [$clog2(SB_ENTRY)-1:0] exe_sb_idx_i,
  input  logic [WORD_SIZE_P-1:0]      exe_sb_addr_i,
  input  logic [WORD_SIZE_P-1:0]      exe_sb_data_i,
  input  logic                        rob_sb_valid_i,
  input  logic                        rob_mispredict_i,
  input  logic [WORD_SIZE_P-1:0]      ld_addr_i,
  output logic                        sb_ld_hit_o,
  output logic [WORD_SIZE_P-1:0]      sb_ld_data_o,
  output logic                        sb_mem_valid_o,
  output logic [WORD_SIZE_P-1:0]      sb_mem_addr_o,
  output logic [WORD_SIZE_P-1:0]      sb_mem_data_o,
  input  logic                        mem_sb_ready_i
);

  localparam int IW = $clog2(SB_ENTRY);
  localparam int CW = IW + 1;

  logic [SB_ENTRY-1:0]    r_valid;
  logic [SB_ENTRY-1:0]    r_filled;
  logic [SB_ENTRY-1:0]    r_cmt;
  logic [WORD_SIZE_P-1:0] r_addr [SB_ENTRY];
  logic [WORD_SIZE_P-1:0] r_data [SB_ENTRY];
  logic [IW-1:0]          r_head;
  logic [IW-1:0]          r_cmtp;
  logic [IW-1:0]          r_tail;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          r_ncmt;

  logic                   w_ready;
  logic                   w_alloc;
  logic                   w_mem_valid;
  logic                   w_drain;
  logic                   w_commit;
  logic                   w_fill;
  logic [IW-1:0]          w_scan;
  logic                   w_hit;
  logic [WORD_SIZE_P-1:0] w_ld_data;

  // r_ncmt counts committed-but-not-drained entries; count minus it is the uncommitted population.
  assign w_ready     = (r_count < CW'(SB_ENTRY)) & ~rob_mispredict_i;
  assign w_alloc     = rename_sb_valid_i & w_ready;
  assign w_mem_valid = r_valid[r_head] & r_cmt[r_head];
  assign w_drain     = w_mem_valid & mem_sb_ready_i;
  assign w_commit    = rob_sb_valid_i & ~rob_mispredict_i & (r_count != r_ncmt);
  assign w_fill      = exe_sb_valid_i & ~rob_mispredict_i & r_valid[exe_sb_idx_i] &
                       ~r_cmt[exe_sb_idx_i] & ~(w_alloc & (exe_sb_idx_i == r_tail));

  assign sb_rename_ready_o = w_ready;
  assign sb_rename_idx_o   = r_tail;
  assign sb_mem_valid_o    = w_mem_valid;
  assign sb_mem_addr_o     = w_mem_valid ? r_addr[r_head] : '0;
  assign sb_mem_data_o     = w_mem_valid ? r_data[r_head] : '0;
  assign sb_ld_hit_o       = w_hit;
  assign sb_ld_data_o      = w_ld_data;

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    w_hit     = 1'b0;
    w_ld_data = '0;
    w_scan    = r_head;
    for (int k = 0; k < SB_ENTRY; k++) begin
      w_scan = r_head + IW'(k);
      if (r_valid[w_scan] && r_filled[w_scan] && (r_addr[w_scan] == ld_addr_i)) begin
        w_hit     = 1'b1;
        w_ld_data = r_data[w_scan];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_valid  <= '0;
      r_filled <= '0;
      r_cmt    <= '0;
      r_head   <= '0;
      r_cmtp   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_ncmt   <= '0;
      for (int i = 0; i < SB_ENTRY; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_fill) begin
        r_filled[exe_sb_idx_i] <= 1'b1;
        r_addr[exe_sb_idx_i]   <= exe_sb_addr_i;
        r_data[exe_sb_idx_i]   <= exe_sb_data_i;
      end
      if (w_commit) begin
        r_cmt[r_cmtp] <= 1'b1;
        r_cmtp        <= r_cmtp + 1'b1;
      end
      if (w_drain) begin
        r_valid[r_head]  <= 1'b0;
        r_filled[r_head] <= 1'b0;
        r_cmt[r_head]    <= 1'b0;
        r_head           <= r_head + 1'b1;
      end
      // Uncommitted entries are exactly the valid ones without the commit mark.
      if (rob_mispredict_i) begin
        for (int i = 0; i < SB_ENTRY; i++) begin
          if (r_valid[i] && !r_cmt[i]) begin
            r_valid[i]  <= 1'b0;
            r_filled[i] <= 1'b0;
          end
        end
        r_tail  <= r_cmtp;
        r_count <= r_ncmt - CW'(w_drain);
      end else begin
        if (w_alloc) begin
          r_valid[r_tail]  <= 1'b1;
          r_filled[r_tail] <= 1'b0;
          r_cmt[r_tail]    <= 1'b0;
          r_addr[r_tail]   <= '0;
          r_data[r_tail]   <= '0;
          r_tail           <= r_tail + 1'b1;
        end
        r_count <= r_count + CW'(w_alloc) - CW'(w_drain);
      end
      r_ncmt <= r_ncmt + CW'(w_commit) - CW'(w_drain);
    end
  end

endmodule
